// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants and enums for the loopback/steering block.
package xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERR   = 8'hFE;

   typedef enum logic [1:0] {
      LB_PASS = 2'd0,
      LB_LOOP = 2'd1,
      LB_IDLE = 2'd2
   } lb_mode_e;

   typedef enum logic {
      GAP   = 1'b0,
      FRAME = 1'b1
   } frame_state_e;

endpackage

// File: rtl/xgmii_delay_line.sv
// Shift register of XGMII {data, ctrl} words, reset to idle; DEPTH = 0 is a plain wire.
module xgmii_delay_line
   import xgmii_pkg::*;
#(
   parameter int LANES = 8,
   parameter int DEPTH = 2
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [8*LANES-1:0] i_d,
   input  logic [LANES-1:0]   i_c,
   output logic [8*LANES-1:0] o_d,
   output logic [LANES-1:0]   o_c
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused_clk;
         assign w_unused_clk = i_clk ^ i_rst_n;
         assign o_d = i_d;
         assign o_c = i_c;
      end else begin : g_pipe
         logic [8*LANES-1:0] r_d [DEPTH];
         logic [LANES-1:0]   r_c [DEPTH];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_d[i] <= {LANES{XGMII_IDLE}};
                  r_c[i] <= '1;
               end
            end else begin
               r_d[0] <= i_d;
               r_c[0] <= i_c;
               for (int i = 1; i < DEPTH; i++) begin
                  r_d[i] <= r_d[i-1];
                  r_c[i] <= r_c[i-1];
               end
            end
         end

         assign o_d = r_d[DEPTH-1];
         assign o_c = r_c[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/xgmii_loopback_mux.sv
// XGMII pass-through / loopback / idle steering with frame-boundary mode switching.
// Optional lane-1 error injection on looped frames: define XGE_LB_ERR_INJECT_EN.
module xgmii_loopback_mux
   import xgmii_pkg::*;
#(
   parameter int LANES    = 8,
   parameter int LB_DELAY = 2,
   parameter int CNT_W    = 16
)(
   input  logic               clk_156m25,
   input  logic               reset_156m25_n,
   input  logic [1:0]         mode_i,
   input  logic               err_inj_i,
   input  logic [8*LANES-1:0] mac_txd,
   input  logic [LANES-1:0]   mac_txc,
   input  logic [8*LANES-1:0] phy_rxd,
   input  logic [LANES-1:0]   phy_rxc,
   output logic [8*LANES-1:0] phy_txd,
   output logic [LANES-1:0]   phy_txc,
   output logic [8*LANES-1:0] mac_rxd,
   output logic [LANES-1:0]   mac_rxc,
   output logic [1:0]         mode_active_o,
   output logic [CNT_W-1:0]   lb_frame_cnt_o
);

   localparam int DW = 8*LANES;
   localparam logic [DW-1:0] IDLE_D = {LANES{XGMII_IDLE}};

   logic [DW-1:0]    r_phy_txd, r_mac_rxd, w_lb_d, w_src_d, w_out_d;
   logic [LANES-1:0] r_phy_txc, r_mac_rxc, w_lb_c, w_src_c, w_out_c;
   lb_mode_e         r_mode, w_req;
   frame_state_e     r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_start, w_term, w_switch;

   xgmii_delay_line #(.LANES(LANES), .DEPTH(LB_DELAY)) u_delay (
      .i_clk   (clk_156m25),
      .i_rst_n (reset_156m25_n),
      .i_d     (mac_txd),
      .i_c     (mac_txc),
      .o_d     (w_lb_d),
      .o_c     (w_lb_c)
   );

   always_comb begin
      w_req = LB_IDLE;
      case (mode_i)
         2'd0:    w_req = LB_PASS;
         2'd1:    w_req = LB_LOOP;
         default: w_req = LB_IDLE;
      endcase
   end

   always_comb begin
      w_src_d = IDLE_D;
      w_src_c = '1;
      case (r_mode)
         LB_PASS: begin w_src_d = phy_rxd; w_src_c = phy_rxc; end
         LB_LOOP: begin w_src_d = w_lb_d;  w_src_c = w_lb_c;  end
         default: ;
      endcase
   end

   assign w_start = w_src_c[0] && (w_src_d[7:0] == XGMII_START);

   always_comb begin
      w_term = 1'b0;
      for (int i = 0; i < LANES; i++)
         if (w_src_c[i] && (w_src_d[8*i +: 8] == XGMII_TERM)) w_term = 1'b1;
   end

   // Switch only between frames, and never on a word that would open one.
   assign w_switch = (w_req != r_mode) && (r_state == GAP) && !w_start;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         GAP:     if (w_start && !w_term) w_state_nxt = FRAME;
         FRAME:   if (w_term) w_state_nxt = GAP;
         default: w_state_nxt = GAP;
      endcase
   end

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) r_state <= GAP;
      else                 r_state <= w_state_nxt;
   end

`ifdef XGE_LB_ERR_INJECT_EN
   logic r_armed, r_after_start, w_inject;

   assign w_inject = r_armed && r_after_start && (r_mode == LB_LOOP) && !w_switch;

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_armed       <= 1'b0;
         r_after_start <= 1'b0;
      end else begin
         r_after_start <= (r_mode == LB_LOOP) && !w_switch && w_start;
         if (w_inject)       r_armed <= 1'b0;
         else if (err_inj_i) r_armed <= 1'b1;
      end
   end
`else
   logic w_unused_err;
   assign w_unused_err = err_inj_i;
`endif

   always_comb begin
      w_out_d = w_src_d;
      w_out_c = w_src_c;
      if (w_switch) begin
         w_out_d = IDLE_D;
         w_out_c = '1;
      end
`ifdef XGE_LB_ERR_INJECT_EN
      else if (w_inject) begin
         w_out_d[15:8] = XGMII_ERR;
         w_out_c[1]    = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_phy_txd <= IDLE_D;
         r_phy_txc <= '1;
         r_mac_rxd <= IDLE_D;
         r_mac_rxc <= '1;
         r_mode    <= LB_PASS;
         r_cnt     <= '0;
      end else begin
         r_phy_txd <= mac_txd;
         r_phy_txc <= mac_txc;
         r_mac_rxd <= w_out_d;
         r_mac_rxc <= w_out_c;
         if (w_switch) r_mode <= w_req;
         if (!w_switch && w_term && (r_mode == LB_LOOP)) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign phy_txd        = r_phy_txd;
   assign phy_txc        = r_phy_txc;
   assign mac_rxd        = r_mac_rxd;
   assign mac_rxc        = r_mac_rxc;
   assign mode_active_o  = r_mode;
   assign lb_frame_cnt_o = r_cnt;

endmodule

// File: tb/tb_xgmii_loopback_mux.sv
// Bench for xgmii_loopback_mux: vector table, directed frame sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_xgmii_loopback_mux;

   localparam int LANES    = 8;
   localparam int LB_DELAY = 2;
   localparam int CNT_W    = 4;

   localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
   localparam logic [63:0] START_D = 64'hD5555555555555FB;
   localparam logic [63:0] TERM4_D = 64'h070707FD44332211;
   localparam logic [63:0] TERM0_D = 64'h07070707070707FD;
   localparam logic [63:0] D1_D    = 64'h1122334455667788;
   localparam logic [63:0] D2_D    = 64'h99AABBCCDDEEF001;
   localparam logic [63:0] PHY_PAT = 64'h0123456789ABCDEF;

   typedef struct packed { logic [63:0] d; logic [7:0] c; } word_t;
   typedef struct {
      logic [1:0] mode; logic [63:0] txd; logic [7:0] txc;
      logic [63:0] rxd; logic [7:0] rxc;
      logic [63:0] exp_d; logic [7:0] exp_c; logic [1:0] exp_mode;
   } vec_t;

   logic             clk_156m25 = 1'b0;
   logic             reset_156m25_n = 1'b0;
   logic [1:0]       mode_i = 2'd0;
   logic             err_inj_i = 1'b0;
   logic [63:0]      mac_txd = IDLE_D;
   logic [7:0]       mac_txc = 8'hFF;
   logic [63:0]      phy_rxd = IDLE_D;
   logic [7:0]       phy_rxc = 8'hFF;
   logic [63:0]      phy_txd, mac_rxd;
   logic [7:0]       phy_txc, mac_rxc;
   logic [1:0]       mode_active_o;
   logic [CNT_W-1:0] lb_frame_cnt_o;

   always #3.2 clk_156m25 = ~clk_156m25;

   xgmii_loopback_mux #(.LANES(LANES), .LB_DELAY(LB_DELAY), .CNT_W(CNT_W)) dut (
      .clk_156m25     (clk_156m25),
      .reset_156m25_n (reset_156m25_n),
      .mode_i         (mode_i),
      .err_inj_i      (err_inj_i),
      .mac_txd        (mac_txd),
      .mac_txc        (mac_txc),
      .phy_rxd        (phy_rxd),
      .phy_rxc        (phy_rxc),
      .phy_txd        (phy_txd),
      .phy_txc        (phy_txc),
      .mac_rxd        (mac_rxd),
      .mac_rxc        (mac_rxc),
      .mode_active_o  (mode_active_o),
      .lb_frame_cnt_o (lb_frame_cnt_o)
   );

   int    checks = 0;
   int    failures = 0;
   word_t lbq[$];
   word_t e_phy_tx, e_mac_rx;
   int    e_mode, e_cnt;
   bit    m_inframe;
`ifdef XGE_LB_ERR_INJECT_EN
   bit    m_armed, m_prev_start;
`endif
   vec_t        tbl[8];
   word_t       fw[8];
   logic [63:0] rx_log[12];
   logic [7:0]  rc_log[12];
   logic [1:0]  md_log[12];
   int          st_tx, st_phy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      lbq.delete();
      for (int i = 0; i < LB_DELAY; i++) lbq.push_back('{IDLE_D, 8'hFF});
      e_phy_tx  = '{IDLE_D, 8'hFF};
      e_mac_rx  = '{IDLE_D, 8'hFF};
      e_mode    = 0;
      e_cnt     = 0;
      m_inframe = 0;
`ifdef XGE_LB_ERR_INJECT_EN
      m_armed      = 0;
      m_prev_start = 0;
`endif
   endtask

   // Next-state of the observable outputs from the current inputs, per the steering rules.
   task automatic model_step();
      word_t tx, lb, src, out;
      bit    st, tm, sw, inj;
      int    req;
      tx = '{mac_txd, mac_txc};
      lbq.push_back(tx);
      lb = lbq.pop_front();
      if (e_mode == 0)      src = '{phy_rxd, phy_rxc};
      else if (e_mode == 1) src = lb;
      else                  src = '{IDLE_D, 8'hFF};
      st = src.c[0] && (src.d[7:0] == 8'hFB);
      tm = 0;
      for (int i = 0; i < LANES; i++)
         if (src.c[i] && (src.d[8*i +: 8] == 8'hFD)) tm = 1;
      req = (mode_i == 2'd0) ? 0 : (mode_i == 2'd1) ? 1 : 2;
      sw  = (req != e_mode) && !m_inframe && !st;
      inj = 0;
`ifdef XGE_LB_ERR_INJECT_EN
      inj = m_armed && m_prev_start && (e_mode == 1) && !sw;
`endif
      out = sw ? '{IDLE_D, 8'hFF} : src;
      if (inj) begin
         out.d[15:8] = 8'hFE;
         out.c[1]    = 1'b1;
      end
      if (!sw && tm && e_mode == 1) e_cnt = (e_cnt + 1) % (1 << CNT_W);
`ifdef XGE_LB_ERR_INJECT_EN
      m_prev_start = (e_mode == 1) && !sw && st;
      if (inj) m_armed = 0;
      else if (err_inj_i) m_armed = 1;
`endif
      if (!m_inframe && st && !tm) m_inframe = 1;
      else if (m_inframe && tm)    m_inframe = 0;
      if (sw) e_mode = req;
      e_mac_rx = out;
      e_phy_tx = tx;
   endtask

   task automatic check_outputs();
      chk("phy_txd", phy_txd, e_phy_tx.d);
      chk("phy_txc", {56'b0, phy_txc}, {56'b0, e_phy_tx.c});
      chk("mac_rxd", mac_rxd, e_mac_rx.d);
      chk("mac_rxc", {56'b0, mac_rxc}, {56'b0, e_mac_rx.c});
      chk("mode_active", {62'b0, mode_active_o}, 64'(e_mode));
      chk("lb_frame_cnt", {60'b0, lb_frame_cnt_o}, 64'(e_cnt));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_156m25);
      #1;
      check_outputs();
   endtask

   task automatic drive_tx(input logic [63:0] d, input logic [7:0] c);
      mac_txd = d;
      mac_txc = c;
   endtask

   task automatic do_reset();
      reset_156m25_n = 1'b0;
      mode_i = 2'd0; err_inj_i = 1'b0;
      drive_tx(IDLE_D, 8'hFF);
      phy_rxd = IDLE_D; phy_rxc = 8'hFF;
      repeat (3) @(posedge clk_156m25);
      #1;
      model_reset();
      chk("rst_mac_rxd", mac_rxd, 64'h0707070707070707);
      chk("rst_mac_rxc", {56'b0, mac_rxc}, 64'hFF);
      chk("rst_phy_txd", phy_txd, 64'h0707070707070707);
      chk("rst_mode", {62'b0, mode_active_o}, 64'd0);
      chk("rst_cnt", {60'b0, lb_frame_cnt_o}, 64'd0);
      reset_156m25_n = 1'b1;
   endtask

   task automatic gen_word(inout int st, output logic [63:0] d, output logic [7:0] c);
      logic [7:0] b;
      d = IDLE_D; c = 8'hFF;
      if ($urandom_range(0, 15) == 0) begin
         c = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
               0: b = 8'h07;  1: b = 8'hFB;  2: b = 8'hFD;  3: b = 8'hFE;
               default: b = 8'($urandom);
            endcase
            d[8*i +: 8] = b;
         end
      end else if (st == 0) begin
         if ($urandom_range(0, 3) == 0) begin
            d = {$urandom, $urandom}; d[7:0] = 8'hFB; c = 8'h01;
            st = $urandom_range(1, 6);
         end
      end else if (st == 1) begin
         int l = $urandom_range(0, 7);
         d = {$urandom, $urandom};
         for (int i = 0; i < 8; i++) begin
            if (i == l)     begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
            else if (i > l) begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
            else            c[i] = 1'b0;
         end
         st = 0;
      end else begin
         d = {$urandom, $urandom}; c = 8'h00;
         st--;
      end
   endtask

   initial begin
      tbl[0] = '{2'd0, 64'hA1A1A1A1A1A1A1A1, 8'h00, 64'hB1B1B1B1B1B1B1B1, 8'h00, 64'hB1B1B1B1B1B1B1B1, 8'h00, 2'd0};
      tbl[1] = '{2'd0, 64'hA2A2A2A2A2A2A2A2, 8'h00, 64'hB2B2B2B2B2B2B2B2, 8'h00, 64'hB2B2B2B2B2B2B2B2, 8'h00, 2'd0};
      tbl[2] = '{2'd2, 64'hA3A3A3A3A3A3A3A3, 8'h00, 64'hB3B3B3B3B3B3B3B3, 8'h00, IDLE_D, 8'hFF, 2'd2};
      tbl[3] = '{2'd2, START_D, 8'h01, START_D, 8'h01, IDLE_D, 8'hFF, 2'd2};
      tbl[4] = '{2'd3, 64'hA5A5A5A5A5A5A5A5, 8'h00, 64'hB5B5B5B5B5B5B5B5, 8'h00, IDLE_D, 8'hFF, 2'd2};
      tbl[5] = '{2'd0, 64'hA6A6A6A6A6A6A6A6, 8'h00, 64'hB6B6B6B6B6B6B6B6, 8'h00, IDLE_D, 8'hFF, 2'd0};
      tbl[6] = '{2'd0, 64'hA7A7A7A7A7A7A7A7, 8'h00, 64'hB7B7B7B7B7B7B7B7, 8'h00, 64'hB7B7B7B7B7B7B7B7, 8'h00, 2'd0};
      tbl[7] = '{2'd0, 64'hA8A8A8A8A8A8A8A8, 8'h00, TERM4_D, 8'hF0, TERM4_D, 8'hF0, 2'd0};

      do_reset();

      // Pass-through / idle / mode-3 vectors
      for (int i = 0; i < 8; i++) begin
         mode_i = tbl[i].mode;
         drive_tx(tbl[i].txd, tbl[i].txc);
         phy_rxd = tbl[i].rxd; phy_rxc = tbl[i].rxc;
         tick();
         chk($sformatf("tbl%0d_rxd", i), mac_rxd, tbl[i].exp_d);
         chk($sformatf("tbl%0d_rxc", i), {56'b0, mac_rxc}, {56'b0, tbl[i].exp_c});
         chk($sformatf("tbl%0d_mode", i), {62'b0, mode_active_o}, {62'b0, tbl[i].exp_mode});
         chk($sformatf("tbl%0d_txd", i), phy_txd, tbl[i].txd);
      end

      // Loopback latency: start seen on mac_rxd three edges after it is driven
      phy_rxd = IDLE_D; phy_rxc = 8'hFF;
      mode_i = 2'd1; drive_tx(IDLE_D, 8'hFF);
      repeat (4) tick();
      chk("lb_mode_on", {62'b0, mode_active_o}, 64'd1);
      drive_tx(START_D, 8'h01); tick();
      chk("lb_phy_txd_start", phy_txd, START_D);
      drive_tx(D1_D, 8'h00); tick();
      chk("lb_not_yet", mac_rxd, 64'h0707070707070707);
      drive_tx(D2_D, 8'h00); tick();
      chk("lb_latency_start", mac_rxd, START_D);
      drive_tx(TERM4_D, 8'hF0); tick();
      drive_tx(IDLE_D, 8'hFF);
      repeat (3) tick();
      chk("lb_cnt_one", {60'b0, lb_frame_cnt_o}, 64'd1);

      // Deferred switch: mode_i drops to 0 on word 2 of an 8-word looped frame
      phy_rxd = PHY_PAT; phy_rxc = 8'h00;
      fw[0] = '{START_D, 8'h01};
      for (int i = 1; i < 7; i++) fw[i] = '{{8{8'(8'h30 + i)}}, 8'h00};
      fw[7] = '{TERM0_D, 8'hFF};
      for (int k = 0; k < 12; k++) begin
         if (k < 8) drive_tx(fw[k].d, fw[k].c);
         else       drive_tx(IDLE_D, 8'hFF);
         if (k == 2) mode_i = 2'd0;
         tick();
         rx_log[k] = mac_rxd; rc_log[k] = mac_rxc; md_log[k] = mode_active_o;
      end
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("defer_word%0d", j), rx_log[j+2], fw[j].d);
         chk($sformatf("defer_mode%0d", j), {62'b0, md_log[j+2]}, 64'd1);
      end
      chk("defer_idle_d", rx_log[10], 64'h0707070707070707);
      chk("defer_idle_c", {56'b0, rc_log[10]}, 64'hFF);
      chk("defer_mode_sw", {62'b0, md_log[10]}, 64'd0);
      chk("defer_phy", rx_log[11], PHY_PAT);

      // Error injection: armed frame vs following frame
      mode_i = 2'd1;
      repeat (4) tick();
      err_inj_i = 1'b1; tick(); err_inj_i = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 7; k++) begin
            case (k)
               0: drive_tx(START_D, 8'h01);
               1: drive_tx(D1_D, 8'h00);
               2: drive_tx(D2_D, 8'h00);
               3: drive_tx(TERM4_D, 8'hF0);
               default: drive_tx(IDLE_D, 8'hFF);
            endcase
            tick();
            rx_log[k] = mac_rxd; rc_log[k] = mac_rxc;
         end
         chk($sformatf("inj_start_f%0d", f), rx_log[2], START_D);
`ifdef XGE_LB_ERR_INJECT_EN
         if (f == 0) begin
            chk("inj_word_d", rx_log[3], 64'h112233445566FE88);
            chk("inj_word_c", {56'b0, rc_log[3]}, 64'h02);
         end else begin
            chk("inj_clear_d", rx_log[3], D1_D);
            chk("inj_clear_c", {56'b0, rc_log[3]}, 64'h00);
         end
`else
         chk($sformatf("noinj_d_f%0d", f), rx_log[3], D1_D);
         chk($sformatf("noinj_c_f%0d", f), {56'b0, rc_log[3]}, 64'h00);
`endif
      end

      // Counter wrap: 17 looped frames with a 4-bit counter
      do_reset();
      mode_i = 2'd1;
      repeat (3) tick();
      for (int f = 0; f < 17; f++) begin
         drive_tx(START_D, 8'h01); tick();
         drive_tx(D1_D, 8'h00);    tick();
         drive_tx(TERM4_D, 8'hF0); tick();
         drive_tx(IDLE_D, 8'hFF);  tick();
      end
      repeat (4) tick();
      chk("cnt_wrap", {60'b0, lb_frame_cnt_o}, 64'd1);

      // Asynchronous reset in the middle of a looped frame
      drive_tx(START_D, 8'h01); tick();
      drive_tx(D1_D, 8'h00);    tick();
      drive_tx(D2_D, 8'h00);    tick();
      #1.5;
      reset_156m25_n = 1'b0;
      #0.5;
      chk("arst_mac_rxd", mac_rxd, 64'h0707070707070707);
      chk("arst_mac_rxc", {56'b0, mac_rxc}, 64'hFF);
      chk("arst_phy_txd", phy_txd, 64'h0707070707070707);
      chk("arst_mode", {62'b0, mode_active_o}, 64'd0);
      chk("arst_cnt", {60'b0, lb_frame_cnt_o}, 64'd0);
      do_reset();

      // Random traffic on both sources with random mode requests and error pulses
      st_tx = 0; st_phy = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [63:0] d;
         logic [7:0]  c;
         gen_word(st_tx, d, c);  drive_tx(d, c);
         gen_word(st_phy, d, c); phy_rxd = d; phy_rxc = c;
         if ($urandom_range(0, 39) == 0) mode_i = 2'($urandom_range(0, 3));
         err_inj_i = ($urandom_range(0, 30) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xgmii_loopback_mux.md
Name: xgmii_loopback_mux

Overview:
- Parametrised XGMII loopback/steering block placed between the MAC XGMII ports and the PHY/serdes model on the 156.25 MHz domain.
- Generalises fixed wire loopback (rxd/rxc tied to txd/txc) in three ways:
  - lane count is a parameter;
  - loopback latency is programmable;
  - mode switches (pass-through / loopback / idle) take effect only at frame boundaries.
- Counts looped frames; optionally injects XGMII error characters.

Parameters:
- LANES, 8, byte lanes per XGMII word; data width 8*LANES, control width LANES; legal 4 or 8.
- LB_DELAY, 2, extra register stages on the loopback path; legal 0..16.
- CNT_W, 16, width of the looped-frame counter.

Ports:
- clk_156m25  input  1  core clock.
- reset_156m25_n  input  1  asynchronous active-low reset.
- mode_i  input  2  requested mode: 0 pass-through, 1 loopback, 2 idle, 3 treated as idle.
- err_inj_i  input  1  error-injection request pulse (used only with the optional feature).
- mac_txd  input  8*LANES  XGMII data from MAC transmit.
- mac_txc  input  LANES  XGMII control from MAC transmit.
- phy_rxd  input  8*LANES  XGMII data from PHY receive.
- phy_rxc  input  LANES  XGMII control from PHY receive.
- phy_txd  output  8*LANES  XGMII data to PHY.
- phy_txc  output  LANES  XGMII control to PHY.
- mac_rxd  output  8*LANES  XGMII data to MAC receive.
- mac_rxc  output  LANES  XGMII control to MAC receive.
- mode_active_o  output  2  mode currently applied (0/1/2).
- lb_frame_cnt_o  output  CNT_W  frames delivered on the loopback path.

Behaviour:
- Clock/reset: one clock, clk_156m25; reset_156m25_n is asynchronous, active-low.
- Reset values:
  - mac_rxd and phy_txd: all lanes 0x07 (idle).
  - mac_rxc and phy_txc: all ones.
  - mode_active_o = 0.
  - lb_frame_cnt_o = 0.
  - Delay line is filled with idle words.
  - Frame state = GAP.
- Reset asserted mid-frame: outputs go idle immediately (asynchronously); no terminate character is synthesised.
- TX path: phy_txd/phy_txc = mac_txd/mac_txc registered once (latency 1), in every mode.
- RX source selection by mode_active_o:
  - Mode 0: phy_rx, latency 1.
  - Mode 1: mac_tx via the delay line, latency 1+LB_DELAY.
  - Mode 2: constant idle.
- Character rules:
  - Start = 0xFB with ctrl=1, lane 0 only.
  - Terminate = 0xFD with ctrl=1, any lane.
  - Error = 0xFE with ctrl=1.
- Frame-state FSM: two states, GAP and FRAME, evaluated on the word at the mux input of the active source.
  - GAP->FRAME on start in lane 0.
  - FRAME->GAP on terminate in any lane.
  - Start and terminate in the same word: the state returns to GAP.
  - Start while in FRAME: ignored (state stays FRAME).
- Mode switching:
  - A pending switch (mode_i differs from mode_active_o, with 3 mapped to 2) is applied on the first cycle where state = GAP and the current source word has no start in lane 0.
  - On the switch cycle, one full idle word is emitted and mode_active_o updates.
  - If mode_i changes again before the switch is applied, the latest value wins.
  - mode_i held stable mid-frame: the switch is deferred until after terminate.
- Counter: lb_frame_cnt_o increments when a terminate word is emitted on mac_rxd while mode_active_o = 1; it wraps modulo 2^CNT_W.
- LB_DELAY = 0: the loopback path is the single output register only.

Optional Feature:
- Macro XGE_LB_ERR_INJECT_EN.
- Defined:
  - A pulse on err_inj_i arms a one-shot flag.
  - On the next word emitted in loopback mode that follows a start word (the first data word of a frame), lane 1 is replaced with 0xFE, ctrl=1. The flag then clears.
  - Further pulses while armed are ignored.
  - Reset clears the flag.
- Undefined: err_inj_i is ignored and no injection logic is present; port list unchanged.

Decomposition:
- Package xgmii_pkg:
  - XGMII_IDLE, XGMII_START, XGMII_TERM, XGMII_ERR byte constants.
  - lb_mode_e enum (LB_PASS, LB_LOOP, LB_IDLE).
  - frame_state_e enum (GAP, FRAME).
- Sub-module xgmii_delay_line:
  - Parameters LANES and DEPTH; shift register of {data, ctrl}.
  - Async-reset to idle.
  - DEPTH = 0 means wire-through.

Test Plan:
- Reset: hold reset_156m25_n low, then release. mac_rxd = 0x0707070707070707, mac_rxc = 0xFF, mode_active_o = 0, counter = 0 on the first clock.
- Loopback latency: mode_i = 1 while idle, then drive a 4-word frame on mac_tx. With LB_DELAY = 2, the start appears on mac_rxd exactly 3 cycles after mac_txd; after terminate, lb_frame_cnt_o = 1.
- Deferred switch: change mode_i 1->0 on word 2 of an 8-word looped frame. All 8 words are delivered, then one idle word, then phy_rx data; mode_active_o changes only after terminate.
- Idle mode: mode_i = 2 with traffic present on both sources. mac_rxd stays all-0x07 and mac_rxc = 0xFF; phy_txd still follows mac_txd with 1-cycle latency.
- Counter wrap: CNT_W = 4, loop 17 frames. lb_frame_cnt_o reads 1.
- Error injection: with XGE_LB_ERR_INJECT_EN defined, pulse err_inj_i, then loop a frame. The first word after start has lane 1 = 0xFE with ctrl bit 1 set; the next frame is unmodified. With the macro undefined, the frame is unmodified.
